// File: rtl/pcie_pkg.sv
// Shared constants for the two-lane receive block: FSM state codes and the
// threshold values loaded at reset.
package pcie_pkg;

    localparam logic [2:0] ST_RESET  = 3'd0;
    localparam logic [2:0] ST_INIT   = 3'd1;
    localparam logic [2:0] ST_IDLE   = 3'd2;
    localparam logic [2:0] ST_ACTIVE = 3'd3;
    localparam logic [2:0] ST_ERROR  = 3'd4;

    // Thresholds in force until the first INIT programs new ones.
    localparam logic [1:0] UMBRAL_IN_DEF  = 2'd1;
    localparam logic [2:0] UMBRAL_OUT_DEF = 3'd2;

endpackage

// File: rtl/pcie_rx_fifo.sv
// Synchronous FIFO with a combinational head and an occupancy count.
// The owner guarantees that push never happens while full and that pop
// never happens while empty, so no guarding is done here.
module rx_fifo
    import pcie_pkg::*;
#(
    parameter int DATA_W = 6,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset_L,
    input  logic                     push,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    // Payload storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_in;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/pcie_rx.sv
// Two-lane receive buffer: each lane fills its own input FIFO, a round-robin
// arbiter merges them one word per cycle into an output FIFO, and the
// consumer reads through a registered data_out/valid_out port.
module pcie_rx
    import pcie_pkg::*;
#(
    parameter int DATA_W    = 6,
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              init,
    input  logic [1:0]        umbral_in,
    input  logic [2:0]        umbral_out,
    input  logic [DATA_W-1:0] data_in0,
    input  logic [DATA_W-1:0] data_in1,
    input  logic              push0,
    input  logic              push1,
    output logic              pause0,
    output logic              pause1,
    input  logic              pop_out,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              active_out,
    output logic              idle_out,
    output logic              error_out
);

    localparam int IN_CW  = $clog2(IN_DEPTH) + 1;
    localparam int OUT_CW = $clog2(OUT_DEPTH) + 1;

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [1:0]        umb_in;
    logic [2:0]        umb_out;
    logic              last_lane;

    logic [IN_CW-1:0]  count0;
    logic [IN_CW-1:0]  count1;
    logic [OUT_CW-1:0] count_o;
    logic [DATA_W-1:0] head0;
    logic [DATA_W-1:0] head1;
    logic [DATA_W-1:0] head_o;

    logic              run;
    logic              ne0, ne1, ne_o;
    logic              full0, full1;
    logic              ovf0, ovf1;
    logic              wr0, wr1;
    logic [IN_CW-1:0]  in_thresh;
    logic [OUT_CW-1:0] out_thresh;
    logic              move;
    logic              sel1;
    logic              rd0, rd1;
    logic [DATA_W-1:0] mv_data;
    logic              pop_hit;

    assign run   = (state == ST_IDLE) || (state == ST_ACTIVE);
    assign ne0   = (count0 != '0);
    assign ne1   = (count1 != '0);
    assign ne_o  = (count_o != '0);
    assign full0 = (count0 == IN_CW'(IN_DEPTH));
    assign full1 = (count1 == IN_CW'(IN_DEPTH));

    // A push into a full lane is lost even if the arbiter drains that lane
    // on the same edge; it is reported as overflow instead.
    assign ovf0 = run && push0 && full0;
    assign ovf1 = run && push1 && full1;
    assign wr0  = run && push0 && !full0;
    assign wr1  = run && push1 && !full1;

    assign in_thresh  = IN_CW'(IN_DEPTH) - IN_CW'(umb_in);
    assign out_thresh = OUT_CW'(OUT_DEPTH) - OUT_CW'(umb_out);

    // Lane 1 wins when it is the only one waiting, or when both wait and
    // lane 0 was served last.
    assign sel1    = ne1 && (!ne0 || !last_lane);
    assign move    = run && (count_o < out_thresh) && (ne0 || ne1);
    assign rd0     = move && !sel1;
    assign rd1     = move && sel1;
    assign mv_data = sel1 ? head1 : head0;
    assign pop_hit = pop_out && ne_o;

    rx_fifo #(.DATA_W(DATA_W), .DEPTH(IN_DEPTH)) u_fifo0 (
        .clk     (clk),
        .reset_L (reset_L),
        .push    (wr0),
        .data_in (data_in0),
        .pop     (rd0),
        .head    (head0),
        .count   (count0)
    );

    rx_fifo #(.DATA_W(DATA_W), .DEPTH(IN_DEPTH)) u_fifo1 (
        .clk     (clk),
        .reset_L (reset_L),
        .push    (wr1),
        .data_in (data_in1),
        .pop     (rd1),
        .head    (head1),
        .count   (count1)
    );

    rx_fifo #(.DATA_W(DATA_W), .DEPTH(OUT_DEPTH)) u_fifo_out (
        .clk     (clk),
        .reset_L (reset_L),
        .push    (move),
        .data_in (mv_data),
        .pop     (pop_hit),
        .head    (head_o),
        .count   (count_o)
    );

    // Next-state logic; overflow takes precedence over the idle/active swap.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RESET:  state_nxt = ST_INIT;
            ST_INIT:   if (!init) state_nxt = ST_IDLE;
            ST_IDLE: begin
                if (ovf0 || ovf1)            state_nxt = ST_ERROR;
                else if (ne0 || ne1 || ne_o) state_nxt = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (ovf0 || ovf1)               state_nxt = ST_ERROR;
                else if (!(ne0 || ne1 || ne_o)) state_nxt = ST_IDLE;
            end
            ST_ERROR:  if (init) state_nxt = ST_INIT;
            default:   state_nxt = ST_RESET;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) state <= ST_RESET;
        else          state <= state_nxt;
    end

    // Thresholds follow the inputs for as long as the FSM sits in INIT.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            umb_in  <= UMBRAL_IN_DEF;
            umb_out <= UMBRAL_OUT_DEF;
        end else if (state == ST_INIT) begin
            umb_in  <= umbral_in;
            umb_out <= umbral_out;
        end
    end

    // Remember which lane was served last; starting at lane 1 gives lane 0
    // the first turn.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L)  last_lane <= 1'b1;
        else if (move) last_lane <= sel1;
    end

    // Backpressure is registered, so it lags the occupancy by one cycle.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            pause0 <= 1'b0;
            pause1 <= 1'b0;
        end else begin
            pause0 <= (count0 >= in_thresh);
            pause1 <= (count1 >= in_thresh);
        end
    end

    // Read port: a pop on an empty FIFO just drops valid and holds the data.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            data_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= pop_hit;
            if (pop_hit) data_out <= head_o;
        end
    end

    assign active_out = (state == ST_ACTIVE);
    assign idle_out   = (state == ST_IDLE);
    assign error_out  = (state == ST_ERROR);

endmodule

// File: tb/tb_pcie_rx.sv
// Self-checking bench for pcie_rx: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_pcie_rx;

    localparam int DW        = 6;
    localparam int IN_DEPTH  = 4;
    localparam int OUT_DEPTH = 8;

    localparam int M_RESET  = 0;
    localparam int M_INIT   = 1;
    localparam int M_IDLE   = 2;
    localparam int M_ACTIVE = 3;
    localparam int M_ERROR  = 4;

    logic          clk;
    logic          reset_L;
    logic          init;
    logic [1:0]    umbral_in;
    logic [2:0]    umbral_out;
    logic [DW-1:0] data_in0;
    logic [DW-1:0] data_in1;
    logic          push0;
    logic          push1;
    logic          pause0;
    logic          pause1;
    logic          pop_out;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          active_out;
    logic          idle_out;
    logic          error_out;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int            st;
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic [DW-1:0] qo[$];
    int            m_uin;
    int            m_uout;
    bit            m_last;
    bit            m_p0;
    bit            m_p1;
    logic [DW-1:0] m_dout;
    bit            m_vld;

    pcie_rx #(.DATA_W(DW), .IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH)) dut (
        .clk        (clk),
        .reset_L    (reset_L),
        .init       (init),
        .umbral_in  (umbral_in),
        .umbral_out (umbral_out),
        .data_in0   (data_in0),
        .data_in1   (data_in1),
        .push0      (push0),
        .push1      (push1),
        .pause0     (pause0),
        .pause1     (pause1),
        .pop_out    (pop_out),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .active_out (active_out),
        .idle_out   (idle_out),
        .error_out  (error_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        st = M_RESET;
        q0.delete();
        q1.delete();
        qo.delete();
        m_uin  = 1;
        m_uout = 2;
        m_last = 1'b1;
        m_p0   = 1'b0;
        m_p1   = 1'b0;
        m_dout = '0;
        m_vld  = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        bit            run;
        bit            ovf0;
        bit            ovf1;
        bit            any;
        bit            mv;
        bit            take1;
        int            nst;
        logic [DW-1:0] w;
        if (!reset_L) begin
            model_reset();
            return;
        end
        run  = (st == M_IDLE) || (st == M_ACTIVE);
        ovf0 = run && push0 && (q0.size() == IN_DEPTH);
        ovf1 = run && push1 && (q1.size() == IN_DEPTH);
        any  = (q0.size() > 0) || (q1.size() > 0) || (qo.size() > 0);
        nst  = st;
        case (st)
            M_RESET:  nst = M_INIT;
            M_INIT:   if (!init) nst = M_IDLE;
            M_IDLE:   if (ovf0 || ovf1) nst = M_ERROR; else if (any) nst = M_ACTIVE;
            M_ACTIVE: if (ovf0 || ovf1) nst = M_ERROR; else if (!any) nst = M_IDLE;
            default:  if (init) nst = M_INIT;
        endcase
        m_p0 = q0.size() >= IN_DEPTH - m_uin;
        m_p1 = q1.size() >= IN_DEPTH - m_uin;
        mv   = run && (qo.size() < OUT_DEPTH - m_uout) && ((q0.size() > 0) || (q1.size() > 0));
        if (pop_out && qo.size() > 0) begin
            m_dout = qo.pop_front();
            m_vld  = 1'b1;
        end else begin
            m_vld = 1'b0;
        end
        if (mv) begin
            if (q0.size() > 0 && q1.size() > 0) take1 = (m_last == 1'b0);
            else                                take1 = (q1.size() > 0);
            if (take1) w = q1.pop_front();
            else       w = q0.pop_front();
            qo.push_back(w);
            m_last = take1;
        end
        if (run && push0 && !ovf0) q0.push_back(data_in0);
        if (run && push1 && !ovf1) q1.push_back(data_in1);
        if (st == M_INIT) begin
            m_uin  = int'(umbral_in);
            m_uout = int'(umbral_out);
        end
        st = nst;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        init     = 1'b0;
        push0    = 1'b0;
        push1    = 1'b0;
        pop_out  = 1'b0;
        data_in0 = '0;
        data_in1 = '0;
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset_L = 1'b1;
    endtask

    task automatic bring_up(input logic [1:0] uin, input logic [2:0] uout);
        clr_inputs();
        do_reset();
        init       = 1'b1;
        umbral_in  = uin;
        umbral_out = uout;
        tick();
        tick();
        init = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        clr_inputs();
        umbral_in  = 2'd1;
        umbral_out = 3'd2;
        reset_L    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({data_out, valid_out, pause0, pause1} !== {{DW{1'b0}}, 3'b000}) begin
            n_fail++;
            $display("FAIL reset_datapath: got %h/%b/%b/%b required 0/0/0/0", data_out, valid_out, pause0, pause1);
        end
        n_checks++;
        if ({active_out, idle_out, error_out} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_state: got %b required 000", {active_out, idle_out, error_out});
        end
        reset_L = 1'b1;
        tick();
        n_checks++;
        if ({active_out, idle_out, error_out} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_to_init: got %b required 000", {active_out, idle_out, error_out});
        end
        tick();
        n_checks++;
        if (idle_out !== 1'b1) begin
            n_fail++;
            $display("FAIL init_skip_to_idle: idle_out got %b required 1", idle_out);
        end
    endtask

    task automatic test_init();
        clr_inputs();
        do_reset();
        init       = 1'b1;
        umbral_in  = 2'd1;
        umbral_out = 3'd2;
        tick();
        tick();
        n_checks++;
        if (idle_out !== 1'b0) begin
            n_fail++;
            $display("FAIL init_held: idle_out got %b required 0", idle_out);
        end
        init = 1'b0;
        tick();
        n_checks++;
        if ({active_out, idle_out, error_out} !== 3'b010) begin
            n_fail++;
            $display("FAIL init_to_idle: state got %b required 010", {active_out, idle_out, error_out});
        end
    endtask

    task automatic test_order();
        logic [DW-1:0] expw [3];
        expw[0] = 6'h05;
        expw[1] = 6'h21;
        expw[2] = 6'h06;
        pop_out  = 1'b1;
        push0    = 1'b1;
        data_in0 = 6'h05;
        push1    = 1'b1;
        data_in1 = 6'h21;
        tick();
        n_checks++;
        if (valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL order_latency_e0: valid_out got %b required 0", valid_out);
        end
        data_in0 = 6'h06;
        push1    = 1'b0;
        tick();
        push0 = 1'b0;
        n_checks++;
        if (valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL order_latency_e1: valid_out got %b required 0", valid_out);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({valid_out, data_out} !== {1'b1, expw[i]}) begin
                n_fail++;
                $display("FAIL order_word%0d: got v=%b d=%h required v=1 d=%h", i, valid_out, data_out, expw[i]);
            end
        end
        tick();
        n_checks++;
        if ({valid_out, data_out, idle_out} !== {1'b0, 6'h06, 1'b1}) begin
            n_fail++;
            $display("FAIL order_empty_pop: got v=%b d=%h idle=%b required v=0 d=06 idle=1", valid_out, data_out, idle_out);
        end
        pop_out = 1'b0;
    endtask

    // Six lane-0 words parked in the output FIFO hold it at the stall level.
    task automatic fill_output();
        for (int i = 0; i < 6; i++) begin
            push0    = 1'b1;
            data_in0 = DW'(6'h10 + i);
            tick();
        end
        push0 = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_pause_stall();
        logic [DW-1:0] got[$];
        logic [DW-1:0] expq[$];
        fill_output();
        for (int i = 0; i < 3; i++) begin
            push1    = 1'b1;
            data_in1 = DW'(6'h30 + i);
            tick();
        end
        push1 = 1'b0;
        n_checks++;
        if (pause1 !== 1'b0) begin
            n_fail++;
            $display("FAIL pause_lag: pause1 got %b required 0", pause1);
        end
        tick();
        n_checks++;
        if ({pause0, pause1} !== 2'b01) begin
            n_fail++;
            $display("FAIL pause_set: pause0/1 got %b required 01", {pause0, pause1});
        end
        tick();
        n_checks++;
        if (pause1 !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_hold: pause1 got %b required 1", pause1);
        end
        pop_out = 1'b1;
        tick();
        if (valid_out) got.push_back(data_out);
        tick();
        if (valid_out) got.push_back(data_out);
        n_checks++;
        if (pause1 !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_no_early_move: pause1 got %b required 1", pause1);
        end
        tick();
        if (valid_out) got.push_back(data_out);
        n_checks++;
        if (pause1 !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_resume: pause1 got %b required 0", pause1);
        end
        for (int i = 0; i < 15; i++) begin
            tick();
            if (valid_out) got.push_back(data_out);
        end
        pop_out = 1'b0;
        for (int i = 0; i < 6; i++) expq.push_back(DW'(6'h10 + i));
        for (int i = 0; i < 3; i++) expq.push_back(DW'(6'h30 + i));
        n_checks++;
        if (got.size() != expq.size()) begin
            n_fail++;
            $display("FAIL stall_drain_count: got %0d words required %0d", got.size(), expq.size());
        end else begin
            for (int i = 0; i < expq.size(); i++) begin
                n_checks++;
                if (got[i] !== expq[i]) begin
                    n_fail++;
                    $display("FAIL stall_drain_word%0d: got %h required %h", i, got[i], expq[i]);
                end
            end
        end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] got[$];
        logic [DW-1:0] expq[$];
        fill_output();
        for (int i = 0; i < 4; i++) begin
            push0    = 1'b1;
            data_in0 = DW'(6'h20 + i);
            tick();
        end
        n_checks++;
        if (error_out !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_premature: error_out got %b required 0", error_out);
        end
        data_in0 = 6'h2F;
        tick();
        push0 = 1'b0;
        n_checks++;
        if ({active_out, idle_out, error_out} !== 3'b001) begin
            n_fail++;
            $display("FAIL ovf_error: state got %b required 001", {active_out, idle_out, error_out});
        end
        pop_out = 1'b1;
        tick();
        pop_out = 1'b0;
        n_checks++;
        if ({valid_out, data_out} !== {1'b1, 6'h10}) begin
            n_fail++;
            $display("FAIL ovf_pop_in_error: got v=%b d=%h required v=1 d=10", valid_out, data_out);
        end
        init = 1'b1;
        tick();
        init = 1'b0;
        n_checks++;
        if ({active_out, idle_out, error_out} !== 3'b000) begin
            n_fail++;
            $display("FAIL ovf_to_init: state got %b required 000", {active_out, idle_out, error_out});
        end
        tick();
        n_checks++;
        if (idle_out !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_reinit_idle: idle_out got %b required 1", idle_out);
        end
        pop_out = 1'b1;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (valid_out) got.push_back(data_out);
        end
        pop_out = 1'b0;
        for (int i = 1; i < 6; i++) expq.push_back(DW'(6'h10 + i));
        for (int i = 0; i < 4; i++) expq.push_back(DW'(6'h20 + i));
        n_checks++;
        if (got.size() != expq.size()) begin
            n_fail++;
            $display("FAIL ovf_drain_count: got %0d words required %0d", got.size(), expq.size());
        end else begin
            for (int i = 0; i < expq.size(); i++) begin
                n_checks++;
                if (got[i] !== expq[i]) begin
                    n_fail++;
                    $display("FAIL ovf_drain_word%0d: got %h required %h", i, got[i], expq[i]);
                end
            end
        end
    endtask

    task automatic test_midreset();
        int stale;
        bring_up(2'd3, 3'd2);
        pop_out = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push0    = 1'b1;
            push1    = 1'b1;
            data_in0 = DW'(6'h2A + i);
            data_in1 = DW'(6'h3C + i);
            tick();
        end
        push0   = 1'b0;
        push1   = 1'b0;
        pop_out = 1'b0;
        n_checks++;
        if ({data_out, valid_out, pause0, pause1, active_out} !== {6'h2A, 4'b1111}) begin
            n_fail++;
            $display("FAIL midreset_before: got d=%h v=%b p=%b%b a=%b required d=2a v=1 p=11 a=1",
                     data_out, valid_out, pause0, pause1, active_out);
        end
        #3;
        reset_L = 1'b0;
        #1;
        n_checks++;
        if ({data_out, valid_out, pause0, pause1, active_out, idle_out, error_out} !== '0) begin
            n_fail++;
            $display("FAIL midreset_async_clear: got d=%h v=%b p=%b%b st=%b required all 0",
                     data_out, valid_out, pause0, pause1, {active_out, idle_out, error_out});
        end
        bring_up(2'd1, 3'd2);
        stale   = 0;
        pop_out = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (valid_out) stale++;
        end
        pop_out = 1'b0;
        n_checks++;
        if (stale != 0 || data_out !== '0) begin
            n_fail++;
            $display("FAIL midreset_stale: got %0d stale words d=%h required 0 words d=00", stale, data_out);
        end
    endtask

    task automatic test_random();
        logic [11:0] act;
        logic [11:0] expv;
        bring_up(2'($urandom), 3'($urandom));
        for (int c = 0; c < 600; c++) begin
            push0      = ($urandom % 4) < 2;
            push1      = ($urandom % 4) < 2;
            data_in0   = DW'($urandom);
            data_in1   = DW'($urandom);
            pop_out    = ($urandom % 3) != 0;
            init       = ($urandom % 16) == 0;
            umbral_in  = 2'($urandom);
            umbral_out = 3'($urandom);
            tick();
            act  = {data_out, valid_out, pause0, pause1, active_out, idle_out, error_out};
            expv = {m_dout, m_vld, m_p0, m_p1, st == M_ACTIVE, st == M_IDLE, st == M_ERROR};
            n_checks++;
            if (act !== expv) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got d=%h v=%b p=%b%b st=%b required d=%h v=%b p=%b%b st=%b",
                         c, act[11:6], act[5], act[4], act[3], act[2:0],
                         expv[11:6], expv[5], expv[4], expv[3], expv[2:0]);
            end
        end
        clr_inputs();
    endtask

    initial begin
        test_reset();
        test_init();
        test_order();
        test_pause_stall();
        test_overflow();
        test_midreset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
